// File: rtl/shaper_event_if.sv
// Event record channel from the shaper supervisor to the downstream consumer.
// Valid/ready handshake carrying amplitude, crossing timestamp and pile-up flag.
interface shaper_event_if #(
   parameter int DATA_W = 31,
   parameter int TS_W   = 32
);
   logic                     ev_valid;
   logic                     ev_ready;
   logic signed [DATA_W-1:0] ev_amp;
   logic [TS_W-1:0]          ev_ts;
   logic                     ev_pileup;

   modport master (
      output ev_valid,
      output ev_amp,
      output ev_ts,
      output ev_pileup,
      input  ev_ready
   );

   modport slave (
      input  ev_valid,
      input  ev_amp,
      input  ev_ts,
      input  ev_pileup,
      output ev_ready
   );
endinterface

// File: rtl/shaper_event_controller.sv
// Supervises the trapezoidal shaping filter: drives its reset, detects threshold
// crossings, samples the flat-top amplitude and emits timestamped event records.
module shaper_event_controller #(
   parameter int DATA_W     = 31,
   parameter int TS_W       = 32,
   parameter int PEAK_DELAY = 8,
   parameter int HOLDOFF    = 16,
   parameter int FLUSH_LEN  = 8
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     enable,
   input  logic                     flush_req,
   input  logic signed [DATA_W-1:0] threshold,
   input  logic signed [DATA_W-1:0] filt_data,
   output logic                     filt_rst_n,
   shaper_event_if.master           ev,
   output logic [15:0]              drop_cnt,
   output logic                     busy
);

   localparam int MAX_A  = (PEAK_DELAY > HOLDOFF) ? PEAK_DELAY : HOLDOFF;
   localparam int MAX_N  = (MAX_A > FLUSH_LEN) ? MAX_A : FLUSH_LEN;
   localparam int CNT_W  = $clog2(MAX_N + 1);

   localparam logic [CNT_W-1:0] FLUSH_LAST = CNT_W'(FLUSH_LEN - 1);
   localparam logic [CNT_W-1:0] PEAK_LAST  = CNT_W'(PEAK_DELAY - 1);
   localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(HOLDOFF - 1);

   typedef enum logic [1:0] {
      ST_FLUSH,
      ST_IDLE,
      ST_WAIT_PEAK,
      ST_HOLDOFF
   } state_t;

   state_t                   state_reg;
   state_t                   state_next;
   logic [CNT_W-1:0]         cnt_reg;
   logic [CNT_W-1:0]         cnt_next;
   logic [TS_W-1:0]          ts_cnt_reg;
   logic [TS_W-1:0]          ts_hold_reg;
   logic [TS_W-1:0]          ts_hold_next;
   logic signed [DATA_W-1:0] amp_hold_reg;
   logic signed [DATA_W-1:0] amp_hold_next;
   logic                     pile_reg;
   logic                     pile_next;
   logic                     above_d_reg;

   logic above;
   logic crossing;
   logic emit;
   logic emit_pile;
   logic ev_load;
   logic ev_drop;

   assign above    = (filt_data > threshold);
   assign crossing = above && !above_d_reg;
   assign busy     = (state_reg != ST_IDLE);

   always_comb begin
      state_next    = state_reg;
      cnt_next      = cnt_reg;
      ts_hold_next  = ts_hold_reg;
      amp_hold_next = amp_hold_reg;
      pile_next     = pile_reg;
      emit          = 1'b0;
      emit_pile     = pile_reg || crossing;

      case (state_reg)
         ST_FLUSH: begin
            if (cnt_reg == FLUSH_LAST) begin
               state_next = ST_IDLE;
               cnt_next   = '0;
            end else begin
               cnt_next = cnt_reg + 1'b1;
            end
         end
         ST_IDLE: begin
            if (enable && crossing) begin
               ts_hold_next = ts_cnt_reg;
               cnt_next     = '0;
               state_next   = ST_WAIT_PEAK;
            end
         end
         ST_WAIT_PEAK: begin
            // A pulse that falls back below threshold before the flat top is noise.
            if (!above) begin
               state_next = ST_IDLE;
               cnt_next   = '0;
            end else if (cnt_reg == PEAK_LAST) begin
               amp_hold_next = filt_data;
               pile_next     = 1'b0;
               cnt_next      = '0;
               state_next    = ST_HOLDOFF;
            end else begin
               cnt_next = cnt_reg + 1'b1;
            end
         end
         ST_HOLDOFF: begin
            if (crossing) begin
               pile_next = 1'b1;
            end
            if (cnt_reg == HOLD_LAST) begin
               emit       = 1'b1;
               cnt_next   = '0;
               state_next = ST_IDLE;
            end else begin
               cnt_next = cnt_reg + 1'b1;
            end
         end
         default: begin
            state_next = ST_FLUSH;
            cnt_next   = '0;
         end
      endcase

      // Flush overrides everything; the count stays pinned while the request is held.
      if (flush_req) begin
         state_next = ST_FLUSH;
         cnt_next   = '0;
         emit       = 1'b0;
      end
   end

   assign ev_load = emit && (!ev.ev_valid || ev.ev_ready);
   assign ev_drop = emit && ev.ev_valid && !ev.ev_ready;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_reg    <= ST_FLUSH;
         cnt_reg      <= '0;
         ts_cnt_reg   <= '0;
         ts_hold_reg  <= '0;
         amp_hold_reg <= '0;
         pile_reg     <= 1'b0;
         above_d_reg  <= 1'b0;
         filt_rst_n   <= 1'b0;
      end else begin
         state_reg    <= state_next;
         cnt_reg      <= cnt_next;
         ts_cnt_reg   <= ts_cnt_reg + 1'b1;
         ts_hold_reg  <= ts_hold_next;
         amp_hold_reg <= amp_hold_next;
         pile_reg     <= pile_next;
         above_d_reg  <= (state_reg == ST_FLUSH) ? 1'b0 : above;
         filt_rst_n   <= (state_next != ST_FLUSH);
      end
   end

   // Output register runs independently of flushes so a pending record is never lost.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ev.ev_valid  <= 1'b0;
         ev.ev_amp    <= '0;
         ev.ev_ts     <= '0;
         ev.ev_pileup <= 1'b0;
         drop_cnt     <= '0;
      end else begin
         if (ev_load) begin
            ev.ev_valid  <= 1'b1;
            ev.ev_amp    <= amp_hold_reg;
            ev.ev_ts     <= ts_hold_reg;
            ev.ev_pileup <= emit_pile;
         end else if (ev.ev_valid && ev.ev_ready) begin
            ev.ev_valid <= 1'b0;
         end
         if (ev_drop && (drop_cnt != 16'hFFFF)) begin
            drop_cnt <= drop_cnt + 16'd1;
         end
      end
   end

endmodule

// File: tb/tb_shaper_event_controller.sv
// Scoreboard bench for shaper_event_controller: directed pulses push expected
// records, a monitor pops and compares on every ev_valid/ev_ready handshake.
module tb_shaper_event_controller;

   localparam int DATA_W = 31;
   localparam int TS_W   = 32;

   typedef struct {
      logic signed [DATA_W-1:0] amp;
      logic [TS_W-1:0]          ts;
      logic                     pile;
   } rec_t;

   logic                     clk;
   logic                     reset;
   logic                     enable;
   logic                     flush_req;
   logic signed [DATA_W-1:0] threshold;
   logic signed [DATA_W-1:0] filt_data;
   logic                     filt_rst_n;
   logic [15:0]              drop_cnt;
   logic                     busy;

   shaper_event_if #(.DATA_W(DATA_W), .TS_W(TS_W)) evif ();

   shaper_event_controller #(
      .DATA_W(DATA_W), .TS_W(TS_W), .PEAK_DELAY(8), .HOLDOFF(16), .FLUSH_LEN(8)
   ) dut (
      .clk(clk),
      .reset(reset),
      .enable(enable),
      .flush_req(flush_req),
      .threshold(threshold),
      .filt_data(filt_data),
      .filt_rst_n(filt_rst_n),
      .ev(evif),
      .drop_cnt(drop_cnt),
      .busy(busy)
   );

   rec_t        exp_q[$];
   rec_t        mon_rec;
   int          n_checks = 0;
   int          n_pass   = 0;
   logic [31:0] edge_cnt;
   logic [31:0] ts1;
   int          lat;
   int          low_cnt;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Timestamp model: counts clock edges since reset release.
   always @(posedge clk or negedge reset) begin
      if (!reset) edge_cnt <= '0;
      else        edge_cnt <= edge_cnt + 32'd1;
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      n_checks++;
      if (act === req) n_pass++;
      else $display("FAIL %s: got %0d, required %0d", name, act, req);
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic count_flush_low(output int cnt);
      cnt = 0;
      while (!filt_rst_n && cnt < 100) begin
         cnt++;
         @(negedge clk);
      end
   endtask

   always @(negedge clk) begin
      #1;
      if (reset && evif.ev_valid && evif.ev_ready) begin
         if (exp_q.size() == 0) begin
            n_checks++;
            $display("FAIL unexpected_event: got amp %0d ts %0d, required no record",
                     evif.ev_amp, evif.ev_ts);
         end else begin
            mon_rec = exp_q.pop_front();
            check("ev_amp", evif.ev_amp, mon_rec.amp);
            check("ev_ts", evif.ev_ts, mon_rec.ts);
            check("ev_pileup", evif.ev_pileup, mon_rec.pile);
            $display("event amp=%0d ts=%0d pileup=%0d", evif.ev_amp, evif.ev_ts, evif.ev_pileup);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, required completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      reset         = 1'b0;
      enable        = 1'b1;
      flush_req     = 1'b0;
      threshold     = 31'sd100;
      filt_data     = '0;
      evif.ev_ready = 1'b1;

      // 1: reset state and power-up flush length
      @(negedge clk);
      check("rst_filt_rst_n", filt_rst_n, 0);
      check("rst_ev_valid", evif.ev_valid, 0);
      check("rst_ev_amp", evif.ev_amp, 0);
      check("rst_ev_ts", evif.ev_ts, 0);
      check("rst_ev_pileup", evif.ev_pileup, 0);
      check("rst_drop_cnt", drop_cnt, 0);
      check("rst_busy", busy, 1);
      reset = 1'b1;
      count_flush_low(low_cnt);
      check("powerup_flush_len", low_cnt, 8);
      check("powerup_busy", busy, 0);
      check("powerup_ev_valid", evif.ev_valid, 0);

      // 2: clean pulse, latency and no retrigger on sustained level
      idle(4);
      filt_data = 31'sd500;
      exp_q.push_back('{31'sd500, edge_cnt, 1'b0});
      lat = -1;
      for (int n = 0; n < 30; n++) begin
         @(negedge clk);
         if (evif.ev_valid && lat < 0) lat = n;
      end
      check("clean_latency", lat, 24);
      check("clean_busy_after", busy, 0);
      filt_data = '0;
      idle(5);

      // 3: glitch aborts in WAIT_PEAK
      filt_data = 31'sd200;
      @(negedge clk);
      check("glitch_armed", busy, 1);
      idle(2);
      check("glitch_still_armed", busy, 1);
      filt_data = '0;
      @(negedge clk);
      check("glitch_abort", busy, 0);
      idle(30);
      check("glitch_drop_cnt", drop_cnt, 0);

      // 4: recross during holdoff flags pile-up, no second event
      filt_data = 31'sd500;
      exp_q.push_back('{31'sd500, edge_cnt, 1'b1});
      idle(12);
      filt_data = '0;
      idle(2);
      filt_data = 31'sd300;
      idle(30);
      check("pileup_busy_after", busy, 0);
      filt_data = '0;
      idle(10);

      // 5: backpressure keeps first record, drops second
      evif.ev_ready = 1'b0;
      idle(5);
      filt_data = 31'sd400;
      ts1 = edge_cnt;
      exp_q.push_back('{31'sd400, ts1, 1'b0});
      idle(30);
      check("bp_first_valid", evif.ev_valid, 1);
      filt_data = '0;
      idle(30);
      filt_data = 31'sd700;
      idle(30);
      filt_data = '0;
      idle(30);
      check("bp_held_valid", evif.ev_valid, 1);
      check("bp_held_amp", evif.ev_amp, 400);
      check("bp_held_ts", evif.ev_ts, ts1);
      check("bp_drop_cnt", drop_cnt, 1);
      evif.ev_ready = 1'b1;
      @(negedge clk);
      check("bp_valid_falls", evif.ev_valid, 0);
      idle(5);

      // 6: flush mid-pulse discards the event; next pulse is captured
      filt_data = 31'sd500;
      idle(5);
      flush_req = 1'b1;
      @(negedge clk);
      flush_req = 1'b0;
      filt_data = '0;
      count_flush_low(low_cnt);
      check("flush_len", low_cnt, 8);
      check("flush_busy_after", busy, 0);
      check("flush_drop_cnt", drop_cnt, 1);
      idle(5);
      filt_data = 31'sd700;
      exp_q.push_back('{31'sd700, edge_cnt, 1'b0});
      idle(30);
      filt_data = '0;
      idle(10);

      // 7: enable low blocks arming
      enable = 1'b0;
      filt_data = 31'sd500;
      idle(3);
      check("disabled_busy", busy, 0);
      filt_data = '0;
      idle(3);
      enable = 1'b1;
      idle(10);

      check("scoreboard_empty", exp_q.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/shaper_event_controller.md
Name: shaper_event_controller

Overview:
- Sequences and supervises the trapezoidal shaping filter that follows the ADC.
- Drives the filter's reset for power-up and on-demand flushes.
- Watches the filter output for threshold crossings and captures the flat-top amplitude a fixed delay after each crossing.
- Flags pile-up and hands timestamped event records downstream over a valid/ready interface.

Parameters:
DATA_W, 31, width of signed filter output and amplitude
TS_W, 32, timestamp counter width
PEAK_DELAY, 8, cycles from crossing sample to amplitude sample (>=1)
HOLDOFF, 16, cycles of pile-up inspection after amplitude capture (>=1)
FLUSH_LEN, 8, cycles filter reset is held low per flush (>=1)

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-low reset
enable  in  1  permits arming from IDLE
flush_req  in  1  level; request filter flush
threshold  in  DATA_W  signed trigger level
filt_data  in  DATA_W  signed filter output, sampled every clk
filt_rst_n  out  1  registered active-low reset to filter
ev_valid  out  1  event record valid
ev_ready  in  1  downstream accepts record
ev_amp  out  DATA_W  captured amplitude
ev_ts  out  TS_W  timestamp of crossing sample
ev_pileup  out  1  recross seen during HOLDOFF
drop_cnt  out  16  events lost to backpressure, saturating
busy  out  1  state != IDLE

Behaviour:
- Reset values:
  - filt_rst_n=0, ev_valid=0, ev_amp=0, ev_ts=0, ev_pileup=0, drop_cnt=0.
  - ts_cnt=0, state=FLUSH, flush counter=0, above_d=0; busy=1.
- ts_cnt: free-running, +1 every clk, wraps at 2^TS_W. Never affected by flush.
- above = (signed filt_data > signed threshold), strict. above_d = above registered.
- crossing = above && !above_d.
- FLUSH:
  - filt_rst_n=0 for exactly FLUSH_LEN cycles, above_d forced 0.
  - Then filt_rst_n=1 and go to IDLE.
- IDLE:
  - On the edge where enable && crossing: latch ts_cnt into ts_hold, peak counter=0, go to WAIT_PEAK.
  - Crossing sample edge = T.
- WAIT_PEAK:
  - At edges T+1..T+PEAK_DELAY, if !above: abort to IDLE, no event, nothing recorded.
  - At edge T+PEAK_DELAY with above: amp_hold=filt_data, pile=0, go to HOLDOFF.
- HOLDOFF:
  - Lasts HOLDOFF cycles, edges T+PEAK_DELAY+1..T+PEAK_DELAY+HOLDOFF.
  - Any crossing in this window sets pile=1. A recross never starts a new event.
  - At the last edge: emit, then go to IDLE.
  - A level still above threshold on return to IDLE does not retrigger; a fresh crossing is required.
- Emit:
  - If !ev_valid, or ev_valid && ev_ready on the same edge: load ev_amp/ev_ts/ev_pileup and set ev_valid=1.
  - Otherwise discard the record; drop_cnt+1, saturating at 16'hFFFF.
- Output register:
  - ev_valid stays high with all fields stable until the ev_valid&&ev_ready edge.
  - On that edge ev_valid clears, unless an emit reloads it on the same edge.
- Latency: crossing edge T -> ev_valid high after edge T+PEAK_DELAY+HOLDOFF.
- flush_req high in any state:
  - Next edge goes to FLUSH and restarts the FLUSH_LEN count.
  - Any in-progress WAIT_PEAK/HOLDOFF event is discarded, not counted as a drop.
  - The output register and its handshake continue unaffected.
  - flush_req held high keeps filt_rst_n low. FLUSH_LEN is counted from the edge where flush_req is seen low.
- enable low:
  - Blocks arming in IDLE only.
  - WAIT_PEAK/HOLDOFF in progress complete normally.
  - flush_req takes priority over everything.
- threshold/enable changes take effect on the next sample; no latching.
- Asynchronous reset mid-operation: everything returns to reset values immediately and a full FLUSH sequence follows.

Test Plan:
1. Reset release with PEAK_DELAY=8, HOLDOFF=16, FLUSH_LEN=8 -> filt_rst_n low exactly 8 cycles after reset deasserts, then high; busy 1→0; ev_valid stays 0.
2. threshold=100, filt_data 0 then 500 from edge T for 30 cycles, ev_ready=1 -> single event valid after edge T+24: amp=500, ts=ts_cnt at T, pileup=0; busy low after.
3. Glitch: filt_data=200 for 3 cycles, then 0 -> no event; IDLE at edge T+3; drop_cnt=0.
4. Pile-up: 500 from T, 0 at T+12, 300 at T+14 -> one event, amp=500, pileup=1; no second event from the recross.
5. Backpressure: ev_ready=0, two clean pulses 60 cycles apart (amps 400, 700) -> first record held stable, second dropped, drop_cnt=1; raise ev_ready -> one handshake, ev_valid falls.
6. flush_req pulsed 1 cycle at T+5 of a pulse -> no event, filt_rst_n low 8 cycles, ts_cnt continuous, next pulse after flush captured normally.
